instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage plus IF/ID pipeline register; direct upstream feeder of InstructionDecode (drives its Instr).
//  Holds PCF, issues one-outstanding requests to instruction memory over a req/valid handshake,
//  and absorbs stall, flush and taken-branch redirects from EX. Issues one fetch per cycle with zero-wait memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) driven on InstrD when no valid instruction
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  Stall      in   1   hazard unit: hold PCF and IF/ID register
//  FlushD     in   1   hazard unit: load bubble into IF/ID
//  PCSrcE     in   1   taken branch/jump resolved in EX
//  PCTargetE  in   32  redirect target from EX
//  imem_req   out  1   fetch request
//  imem_addr  out  32  fetch address; stable while imem_req=1 and imem_valid=0
//  imem_rdata in   32  instruction word, sampled when imem_valid=1
//  imem_valid in   1   response strobe; may assert in the request cycle (combinational memory) or later
//  InstrD     out  32  instruction to decode
//  PCD        out  32  PC of InstrD
//  PCPlus4D   out  32  PCD+4
//  ValidD     out  1   InstrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, rst_n=0): PCF=RESET_PC, ReqAddr=RESET_PC, state=IDLE, imem_req=0, imem_addr=ReqAddr,
//   InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. All D outputs registered; imem_addr=ReqAddr (registered).
//  Arithmetic: PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0). PCTargetE[1:0] forced to 00 on capture.
//  FSM states: IDLE, FETCH, HOLD, DROP. imem_req=1 in FETCH and DROP only.
//   IDLE : -> FETCH next cycle (first request at RESET_PC).
//   FETCH: waiting for response at ReqAddr.
//     valid & PCSrcE        : discard data; PCF=ReqAddr=target; stay FETCH.
//     valid & Stall         : latch rdata/ReqAddr into InstrBuf/PCBuf; -> HOLD.
//     valid (else)          : deliver {rdata, ReqAddr}; PCF=ReqAddr=ReqAddr+4; stay FETCH.
//     !valid & PCSrcE       : PCF=target; -> DROP (address kept stable, response discarded).
//   HOLD : buffered instruction, no request.
//     PCSrcE                : discard buffer; PCF=ReqAddr=target; -> FETCH.
//     !Stall                : deliver buffer; PCF=ReqAddr=PCBuf+4; -> FETCH.
//   DROP : request outstanding to stale address.
//     PCSrcE                : PCF=target (latest redirect wins).
//     valid                 : discard data; ReqAddr=PCF (target registered in same cycle if PCSrcE); -> FETCH.
//  IF/ID register, priority FlushD > Stall > deliver > bubble:
//   FlushD: InstrD=NOP_INSTR, ValidD=0, PCD=PCPlus4D=0 (overrides Stall and discards any delivery).
//   Stall : all D outputs hold.
//   deliver: InstrD=instr, PCD=addr, PCPlus4D=addr+4, ValidD=1.
//   no delivery this cycle: bubble as for FlushD.
//  Latency: request at cycle N, imem_valid at N+k (k>=0), InstrD valid after edge ending cycle N+k.
//  Rule: an instruction from a discarded response or stale address never reaches ValidD=1.
//  Rule: Stall never drops a returned instruction (HOLD buffers exactly one).
//  Reset mid-operation: immediate return to reset values; an outstanding memory response is ignored (IDLE has no req).
// TESTING
//  T1 zero-wait memory (valid=req), RESET_PC=0, rdata=addr^0xA5 -> PCD 0,4,8,C on consecutive cycles, ValidD=1 from cycle 2.
//  T2 two-cycle memory latency -> imem_addr held stable 2 cycles each; ValidD pattern 0,1,0,1...; PCD increments by 4.
//  T3 Stall=1 for 3 cycles while valid returns for PC=0x8 -> state HOLD, imem_req=0, D outputs frozen; after release PCD=0x8 once, next fetch 0xC.
//  T4 PCSrcE=1, PCTargetE=0x103 while waiting on 0x10 -> DROP; 0x10 response discarded; next imem_addr=0x100; first ValidD=1 has PCD=0x100.
//  T5 FlushD and Stall together with valid delivery -> InstrD=0x00000013, ValidD=0; PCF advances normally.
//  T6 start at 0xFFFF_FFFC -> next imem_addr=0x0000_0000; rst_n low mid-wait -> outputs reset asynchronously, late imem_valid ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with the IF/ID pipeline register.
// Keeps at most one request outstanding to instruction memory over a req/valid
// handshake. Stall, flush and taken-branch redirects from EX are absorbed here,
// so the decode stage only ever sees instructions that are on the correct path.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // out of reset, no request yet
    FETCH = 2'd1,  // request outstanding at req_addr
    HOLD  = 2'd2,  // one returned instruction parked in the buffer
    DROP  = 2'd3   // request outstanding to an address made stale by a redirect
  } state_t;

  state_t      state;
  logic [31:0] pcf;        // architectural fetch PC
  logic [31:0] req_addr;   // address presented to memory
  logic [31:0] instr_buf;  // instruction parked while decode is stalled
  logic [31:0] pc_buf;     // PC of the parked instruction
  logic        req_q;

  // Redirect targets are word aligned; the low two bits are dropped on capture.
  logic [31:0] target;
  assign target = PCTargetE & ~32'h0000_0003;

  assign imem_req  = req_q;
  assign imem_addr = req_addr;

  // An instruction is handed to IF/ID only when it is on the correct path and
  // decode is free to take it.
  logic        deliver;
  logic [31:0] del_instr;
  logic [31:0] del_addr;

  // Select the instruction (if any) that moves into IF/ID this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    deliver   = 1'b0;
    del_instr = imem_rdata;
    del_addr  = req_addr;
    unique case (state)
      FETCH: deliver = imem_valid && !PCSrcE && !Stall;
      HOLD: begin
        deliver   = !PCSrcE && !Stall;
        del_instr = instr_buf;
        del_addr  = pc_buf;
      end
      default: deliver = 1'b0;
    endcase
  end

  // Fetch control FSM: PC, request address, request strobe and stall buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcf       <= RESET_PC;
      req_addr  <= RESET_PC;
      req_q     <= 1'b0;
      // NOTE: the one-entry buffer is reset as well; it is a single register,
      // not a RAM, and a defined value keeps X out of any debug view of it.
      instr_buf <= NOP_INSTR;
      pc_buf    <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      unique case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_valid && PCSrcE) begin
            pcf      <= target;
            req_addr <= target;
          end else if (imem_valid && Stall) begin
            instr_buf <= imem_rdata;
            pc_buf    <= req_addr;
            state     <= HOLD;
            req_q     <= 1'b0;
          end else if (imem_valid) begin
            pcf      <= req_addr + 32'd4;
            req_addr <= req_addr + 32'd4;
          end else if (PCSrcE) begin
            // The memory still owes a response for req_addr; keep the address
            // stable and throw that response away when it arrives.
            pcf   <= target;
            state <= DROP;
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            pcf      <= target;
            req_addr <= target;
            state    <= FETCH;
            req_q    <= 1'b1;
          end else if (!Stall) begin
            pcf      <= pc_buf + 32'd4;
            req_addr <= pc_buf + 32'd4;
            state    <= FETCH;
            req_q    <= 1'b1;
          end
        end
        DROP: begin
          if (PCSrcE) pcf <= target;
          if (imem_valid) begin
            // A redirect arriving together with the stale response wins.
            req_addr <= PCSrcE ? target : pcf;
            state    <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (!Stall) begin
      if (deliver) begin
        InstrD   <= del_instr;
        PCD      <= del_addr;
        PCPlus4D <= del_addr + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= 32'h0;
        PCPlus4D <= 32'h0;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a program-order model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  instruction_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Stall      (Stall),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  // Memory model: answers a request after cur_lat extra cycles (0 = same cycle).
  logic mem_hold  = 1'b0;  // suppress responses
  logic force_v   = 1'b0;  // inject a spurious response
  logic rand_mode = 1'b0;
  int   base_lat  = 0;
  int   cur_lat   = 0;
  int   wait_cnt  = 0;

  assign imem_valid = force_v | (imem_req & !mem_hold & (wait_cnt >= cur_lat));
  assign imem_rdata = force_v ? 32'hBAD0_0000 :
                      (imem_valid ? (imem_addr ^ 32'h0000_00A5) : 32'hDEAD_BEEF);

  always @(posedge clk) begin
    if (!imem_req || imem_valid) begin
      wait_cnt <= 0;
      cur_lat  <= rand_mode ? int'($urandom_range(2, 0)) : base_lat;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic        prev_req;
  logic        prev_valid;
  logic [31:0] prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // D-stage outputs for either a real instruction at pc or a bubble.
  task automatic check_d(input string name, input logic vd, input logic [31:0] pc);
    check({name, ".ValidD"}, {31'h0, ValidD}, {31'h0, vd});
    check({name, ".PCD"}, PCD, vd ? pc : 32'h0);
    check({name, ".PCPlus4D"}, PCPlus4D, vd ? pc + 32'd4 : 32'h0);
    check({name, ".InstrD"}, InstrD, vd ? (pc ^ 32'h0000_00A5) : NOP);
  endtask

  task automatic check_req(input string name, input logic req, input logic [31:0] addr);
    check({name, ".imem_req"}, {31'h0, imem_req}, {31'h0, req});
    check({name, ".imem_addr"}, imem_addr, addr);
  endtask

  // One clock: record pre-edge handshake, then sample 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    prev_req   = imem_req;
    prev_valid = imem_valid;
    prev_addr  = imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rmode);
    @(negedge clk);
    rst_n     = 1'b0;
    Stall     = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    mem_hold  = 1'b0;
    force_v   = 1'b0;
    base_lat  = lat;
    rand_mode = rmode;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        pcsrc;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        vd;
    logic [31:0] pcd;
  } vec_t;

  vec_t vecs[18];

  // Reference-model state for the randomized run.
  logic [31:0] exp_next;
  logic        h_v;
  logic [31:0] h_pc;
  int          deliveries;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Zero-wait memory vectors: {stall, flush, pcsrc, target, req, addr, ValidD, PCD}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 32'h200, 1'b1, 32'h100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 32'h200};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h43,  1'b1, 32'h40,  1'b1, 32'h200};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h40};

    // Reset values
    do_reset(0, 1'b0);
    check_req("reset", 1'b0, 32'h0);
    check_d("reset", 1'b0, 32'h0);

    // Zero-wait fetch, stall/HOLD, flush, redirects
    foreach (vecs[i]) begin
      Stall     = vecs[i].stall;
      FlushD    = vecs[i].flush;
      PCSrcE    = vecs[i].pcsrc;
      PCTargetE = vecs[i].target;
      step();
      check_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr);
      check_d($sformatf("vec%0d", i), vecs[i].vd, vecs[i].pcd);
    end
    Stall = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;

    // Two-cycle memory: address held two cycles, ValidD alternates
    do_reset(1, 1'b0);
    step();
    check_req("lat2.first", 1'b1, 32'h0);
    step();
    check_req("lat2.wait", 1'b1, 32'h0);
    check_d("lat2.wait", 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_d($sformatf("lat2.del%0d", k), 1'b1, 32'(4 * k));
      check_req($sformatf("lat2.del%0d", k), 1'b1, 32'(4 * k + 4));
      step();
      check_d($sformatf("lat2.gap%0d", k), 1'b0, 32'h0);
      check_req($sformatf("lat2.gap%0d", k), 1'b1, 32'(4 * k + 4));
    end

    // Redirect while waiting on 0x10: stale response dropped
    do_reset(0, 1'b0);
    repeat (5) step();
    check_req("drop.pre", 1'b1, 32'h10);
    mem_hold = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h103;
    step();
    check_req("drop.enter", 1'b1, 32'h10);
    PCSrcE = 1'b0;
    step();
    check_req("drop.wait", 1'b1, 32'h10);
    check_d("drop.wait", 1'b0, 32'h0);
    mem_hold = 1'b0;
    step();
    check_req("drop.exit", 1'b1, 32'h100);
    check_d("drop.exit", 1'b0, 32'h0);
    step();
    check_d("drop.first", 1'b1, 32'h100);
    // Second redirect arrives together with the stale response: it wins
    mem_hold = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h203;
    step();
    check_req("drop2.enter", 1'b1, 32'h104);
    mem_hold = 1'b0; PCTargetE = 32'h303;
    step();
    check_req("drop2.exit", 1'b1, 32'h300);
    check_d("drop2.exit", 1'b0, 32'h0);
    PCSrcE = 1'b0;
    step();
    check_d("drop2.first", 1'b1, 32'h300);

    // Address wrap, then asynchronous reset while waiting
    do_reset(0, 1'b0);
    step();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    step();
    check_req("wrap.target", 1'b1, 32'hFFFF_FFFC);
    PCSrcE = 1'b0;
    step();
    check_d("wrap.del", 1'b1, 32'hFFFF_FFFC);
    check_req("wrap.next", 1'b1, 32'h0);
    mem_hold = 1'b1;
    step();
    check_req("rst.wait", 1'b1, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_req("rst.async", 1'b0, 32'h0);
    check_d("rst.async", 1'b0, 32'h0);
    mem_hold = 1'b0; force_v = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_req("rst.late_valid", 1'b1, 32'h0);
    check_d("rst.late_valid", 1'b0, 32'h0);
    force_v = 1'b0;
    step();
    check_d("rst.first", 1'b1, 32'h0);

    // Randomized run against a program-order model
    do_reset(0, 1'b1);
    exp_next   = 32'h0;
    h_v        = 1'b0;
    h_pc       = 32'h0;
    deliveries = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      Stall     = ($urandom_range(3, 0) == 0);
      PCSrcE    = (cyc > 4) && ($urandom_range(11, 0) == 0);
      FlushD    = PCSrcE && ($urandom_range(1, 0) == 1);
      PCTargetE = $urandom;
      step();
      if (prev_req && !prev_valid) begin
        check("rand.req_held", {31'h0, imem_req}, 32'h1);
        check("rand.addr_stable", imem_addr, prev_addr);
      end
      if (FlushD) begin
        check_d("rand.flush", 1'b0, 32'h0);
        h_v = 1'b0; h_pc = 32'h0;
      end else if (Stall) begin
        check_d("rand.stall", h_v, h_pc);
      end else if (PCSrcE || !ValidD) begin
        check_d("rand.bubble", 1'b0, 32'h0);
        h_v = 1'b0; h_pc = 32'h0;
      end else begin
        check_d("rand.deliver", 1'b1, exp_next);
        h_v = 1'b1; h_pc = exp_next;
        exp_next = exp_next + 32'd4;
        deliveries++;
      end
      if (PCSrcE) exp_next = PCTargetE & ~32'h3;
    end
    check("rand.progress", {31'h0, deliveries > 400}, 32'h1);
    Stall = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
